flag_buf_arbiter: RTL and testbench

//  Shares one flag_buf single-word mailbox among N producers with round-robin fairness.

---
 rtl/flag_buf_arbiter.sv | 111 +++++++++++
 tb/tb_flag_buf_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_buf_arbiter.sv
// Round-robin arbiter that lets N producers share one flag_buf mailbox word.
// Sequences set_flag/clr_flag around each word and reports the producer id it holds.
module flag_buf_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  din_bus,
    output logic [N-1:0]    gnt,
    input  logic            rd_ack,
    input  logic            buf_flag,
    output logic            set_flag,
    output logic            clr_flag,
    output logic [W-1:0]    buf_din,
    output logic [IW-1:0]   src_id,
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, LOAD, FULL, DRAIN, WAIT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [N-1:0]    gnt_n;
    logic            set_n, clr_n, busy_n;
    logic [W-1:0]    din_n;
    logic [IW-1:0]   id_n;
    logic [IW-1:0]   sel, idx;
    logic            found;
    logic [W-1:0]    words [N];

    for (genvar g = 0; g < N; g++) begin : g_words
        assign words[g] = din_bus[g*W +: W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt      <= '0;
            set_flag <= 1'b0;
            clr_flag <= 1'b0;
            buf_din  <= '0;
            src_id   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            set_flag <= set_n;
            clr_flag <= clr_n;
            buf_din  <= din_n;
            src_id   <= id_n;
            busy     <= busy_n;
        end
    end

    // First requester at or after the pointer, scanning cyclically.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = '0;
        set_n   = 1'b0;
        clr_n   = 1'b0;
        din_n   = buf_din;
        id_n    = src_id;
        case (state)
            IDLE: begin
                if (!buf_flag && found) begin
                    gnt_n[sel] = 1'b1;
                    set_n      = 1'b1;
                    din_n      = words[sel];
                    id_n       = sel;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                ptr_n   = (src_id == IW'(N-1)) ? '0 : src_id + IW'(1);
                state_n = FULL;
            end
            FULL: begin
                if (rd_ack && buf_flag) begin
                    clr_n   = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: state_n = WAIT;
            WAIT: begin
                if (!buf_flag) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_flag_buf_arbiter.sv
// Randomized self-checking bench for flag_buf_arbiter with a behavioural flag_buf
// and a transaction-level reference model of the arbiter.
module tb_flag_buf_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  din_bus;
    logic [N-1:0]    gnt;
    logic            rd_ack;
    logic            buf_flag;
    logic            set_flag, clr_flag;
    logic [W-1:0]    buf_din;
    logic [IW-1:0]   src_id;
    logic            busy;

    logic            flagReg;
    logic            forceFlag;
    int              forceCnt;
    logic [W-1:0]    prodData [N];

    int vectorCount = 0;
    int missCount   = 0;

    // Reference model: word-in-flight bookkeeping with cycle counters.
    bit              inWord, acked;
    int              sinceGrant, sinceAck, rrPtr;
    logic [N-1:0]    expGnt;
    logic            expSet, expClr, expBusy;
    logic [W-1:0]    expDin;
    logic [IW-1:0]   expId;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign din_bus[g*W +: W] = prodData[g];
    end

    assign buf_flag = flagReg | forceFlag;

    always @(posedge clk or negedge reset) begin
        if (!reset)        flagReg <= 1'b0;
        else if (set_flag) flagReg <= 1'b1;
        else if (clr_flag) flagReg <= 1'b0;
    end

    flag_buf_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .din_bus  (din_bus),
        .gnt      (gnt),
        .rd_ack   (rd_ack),
        .buf_flag (buf_flag),
        .set_flag (set_flag),
        .clr_flag (clr_flag),
        .buf_din  (buf_din),
        .src_id   (src_id),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("gnt",      32'(gnt),      32'(expGnt));
        checkOutput("set_flag", 32'(set_flag), 32'(expSet));
        checkOutput("clr_flag", 32'(clr_flag), 32'(expClr));
        checkOutput("busy",     32'(busy),     32'(expBusy));
        checkOutput("src_id",   32'(src_id),   32'(expId));
        checkOutput("buf_din",  32'(buf_din),  32'(expDin));
    endtask

    task automatic modelReset();
        inWord = 0; acked = 0; sinceGrant = 0; sinceAck = 0; rrPtr = 0;
        expGnt = '0; expSet = 0; expClr = 0; expBusy = 0; expDin = '0; expId = '0;
    endtask

    task automatic modelStep();
        int w;
        w = -1;
        if (!inWord) begin
            expGnt = '0; expSet = 0; expClr = 0;
            if (!buf_flag) begin
                for (int i = 0; i < N; i++) begin
                    if (w < 0 && req[(rrPtr + i) % N]) w = (rrPtr + i) % N;
                end
            end
            if (w >= 0) begin
                expGnt[w] = 1'b1;
                expSet = 1;
                expDin = prodData[w];
                expId = IW'(w);
                inWord = 1; sinceGrant = 0; acked = 0;
            end
        end else if (sinceGrant == 0) begin
            expGnt = '0; expSet = 0;
            rrPtr = (int'(expId) + 1) % N;
            sinceGrant = 1;
        end else if (!acked) begin
            if (rd_ack && buf_flag) begin
                acked = 1; sinceAck = 0; expClr = 1;
            end
        end else if (sinceAck == 0) begin
            expClr = 0; sinceAck = 1;
        end else if (!buf_flag) begin
            inWord = 0;
        end
        expBusy = inWord;
    endtask

    task automatic applyStimulus();
        #1;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic randomizeInputs();
        for (int i = 0; i < N; i++) begin
            if (req[i] && gnt[i]) req[i] = 1'b0;
            else if (req[i]) begin
                if ($urandom_range(31) == 0) req[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                req[i] = 1'b1;
                prodData[i] = W'($urandom);
            end else begin
                prodData[i] = W'($urandom);
            end
        end
        rd_ack = ($urandom_range(2) == 0);
        if (forceCnt > 0) forceCnt--;
        else if ($urandom_range(40) == 0) forceCnt = int'($urandom_range(4, 1));
        forceFlag = (forceCnt > 0);
    endtask

    task automatic runUntilIdle(input int budget);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            req = req & ~gnt;
            applyStimulus();
            if (!expBusy && !busy) done = 1;
        end
        if (!done) checkOutput("idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int k;
        reset = 1'b0; req = '0; rd_ack = 1'b0; forceFlag = 1'b0; forceCnt = 0;
        for (int i = 0; i < N; i++) prodData[i] = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        reset = 1'b1;

        // Single requester with rd_ack held high from the start.
        req = 4'b0100; prodData[2] = 8'hA5; rd_ack = 1'b1;
        applyStimulus();
        checkOutput("t1_gnt", 32'(gnt), 32'h4);
        checkOutput("t1_src_id", 32'(src_id), 32'h2);
        checkOutput("t1_buf_din", 32'(buf_din), 32'hA5);
        req = '0;
        applyStimulus();
        checkOutput("t1_flag", 32'(buf_flag), 32'h1);
        checkOutput("t3_no_early_clr", 32'(clr_flag), 32'h0);
        applyStimulus();
        checkOutput("t3_clr", 32'(clr_flag), 32'h1);
        applyStimulus();
        checkOutput("t3_busy_held", 32'(busy), 32'h1);
        applyStimulus();
        checkOutput("t3_busy_drop", 32'(busy), 32'h0);
        rd_ack = 1'b0;

        // Stale flag blocks arbitration until released.
        forceFlag = 1'b1; req = 4'b0001; prodData[0] = 8'h3C;
        repeat (3) begin
            applyStimulus();
            checkOutput("t5_no_gnt", 32'(gnt), 32'h0);
            checkOutput("t5_no_set", 32'(set_flag), 32'h0);
        end
        forceFlag = 1'b0;
        applyStimulus();
        checkOutput("t5_gnt", 32'(gnt), 32'h1);
        req = '0; rd_ack = 1'b1;
        runUntilIdle(20);

        // Asynchronous reset while a word sits in FULL.
        rd_ack = 1'b0; req = 4'b0010; prodData[1] = 8'h5A;
        applyStimulus();
        req = '0;
        repeat (3) applyStimulus();
        checkOutput("t4_busy_before", 32'(busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t4_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("t4_rst_set", 32'(set_flag), 32'h0);
        checkOutput("t4_rst_clr", 32'(clr_flag), 32'h0);
        checkOutput("t4_rst_din", 32'(buf_din), 32'h0);
        checkOutput("t4_rst_id", 32'(src_id), 32'h0);
        checkOutput("t4_rst_busy", 32'(busy), 32'h0);
        modelReset();
        @(negedge clk);
        req = 4'b1000; prodData[3] = 8'hC3; reset = 1'b1;
        applyStimulus();
        checkOutput("t4_gnt", 32'(gnt), 32'h8);
        req = '0; rd_ack = 1'b1;
        runUntilIdle(20);

        // All producers requesting: strict rotation with each one's own word.
        prodData[0] = 8'h11; prodData[1] = 8'h22; prodData[2] = 8'h33; prodData[3] = 8'h44;
        req = 4'b1111; rd_ack = 1'b1; k = 0;
        for (int c = 0; c < 80 && k < 5; c++) begin
            applyStimulus();
            if (gnt != '0) begin
                checkOutput("t2_order", 32'(src_id), 32'(order[k]));
                checkOutput("t2_data", 32'(buf_din), 32'(prodData[order[k]]));
                k++;
            end
        end
        if (k < 5) checkOutput("t2_timeout", 32'(k), 32'd5);
        req = '0;
        runUntilIdle(20);

        // Randomized traffic against the reference model.
        rd_ack = 1'b0;
        repeat (2000) begin
            randomizeInputs();
            applyStimulus();
        end
        forceCnt = 0; forceFlag = 1'b0; req = '0; rd_ack = 1'b1;
        runUntilIdle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
